// File: rtl/inv_sub_bytes_seq_pkg.sv
// Shared AES constants: state geometry, FSM encoding and the FIPS-197 S-box tables.
package inv_sub_bytes_seq_pkg;

   localparam int unsigned STATE_W   = 128;
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned NUM_BYTES = 16;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

endpackage

// File: rtl/inv_sub_bytes_seq_inv_sbox.sv
// Combinational FIPS-197 inverse S-box lookup for one byte.
module inv_sbox
   import inv_sub_bytes_seq_pkg::*;
(
   input  logic [7:0] sel_byte,
   output logic [7:0] sub_byte
);

   always_comb begin
      sub_byte = INV_SBOX[sel_byte];
   end

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential inverse SubBytes: substitutes LANES bytes per cycle in place, valid/ready on both sides.
module inv_sub_bytes_seq
   import inv_sub_bytes_seq_pkg::*;
#(
   parameter int unsigned LANES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out
);

   localparam int unsigned NUM_GROUPS = NUM_BYTES / LANES;
   localparam int unsigned GROUP_W    = LANES * BYTE_W;
   localparam int unsigned CNT_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
   localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NUM_GROUPS - 1);

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
      $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
   end

   state_t             state, state_nxt;
   logic [STATE_W-1:0] work, work_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [GROUP_W-1:0] group_sel, group_sub;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)          state_nxt = BUSY;
         BUSY:    if (cnt == LAST_GRP)   state_nxt = DONE;
         DONE:    if (out_ready)         state_nxt = IDLE;
         default:                        state_nxt = IDLE;
      endcase
   end

   // Group select and write-back are decoded per group so the LANES sboxes are shared across all groups.
   always_comb begin
      group_sel = '0;
      work_nxt  = work;
      for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
         if (cnt == CNT_W'(g)) begin
            group_sel                      = work[g*GROUP_W +: GROUP_W];
            work_nxt[g*GROUP_W +: GROUP_W] = group_sub;
         end
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      inv_sbox u_inv_sbox (
         .sel_byte (group_sel[l*BYTE_W +: BYTE_W]),
         .sub_byte (group_sub[l*BYTE_W +: BYTE_W])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work <= '0;
         cnt  <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               work <= state_in;
               cnt  <= '0;
            end
            BUSY: begin
               work <= work_nxt;
               cnt  <= (cnt == LAST_GRP) ? '0 : cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign state_out = work;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq at LANES = 4, 1 and 16.
module tb_inv_sub_bytes_seq;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic [127:0] state_in  [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [127:0] state_out [3];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int unsigned LN = (k == 0) ? 4 : (k == 1) ? 1 : 16;
      inv_sub_bytes_seq #(.LANES(LN)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[k]),
         .in_ready  (in_ready[k]),
         .state_in  (state_in[k]),
         .out_valid (out_valid[k]),
         .out_ready (out_ready[k]),
         .state_out (state_out[k])
      );
   end

   localparam logic [127:0] FILL63  = {16{8'h63}};
   localparam logic [127:0] FILL52  = {16{8'h52}};
   localparam logic [127:0] RT_ORIG = 128'h19a09ae93df4c6f8e3e28d48be2b2a08;
   localparam logic [127:0] RT_SUB  = 128'hd4e0b81e27bfb44111985d52aef1e530;

   function automatic int lat_of(input int d);
      return (d == 0) ? 4 : (d == 1) ? 16 : 1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one block, count edges until out_valid, check the result and the return to IDLE.
   task automatic send(input int d, input logic [127:0] data, input logic [127:0] expv, input string nm);
      int n;
      state_in[d]  = data;
      in_valid[d]  = 1'b1;
      out_ready[d] = 1'b1;
      tick();
      in_valid[d] = 1'b0;
      n_cmp++;
      if (in_ready[d] !== 1'b0) begin
         n_bad++; $display("FAIL %s_busy_ready d%0d: got %b want 0", nm, d, in_ready[d]);
      end
      n = 0;
      while (out_valid[d] !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      n_cmp++;
      if (n != lat_of(d)) begin
         n_bad++; $display("FAIL %s_latency d%0d: got %0d want %0d", nm, d, n, lat_of(d));
      end
      n_cmp++;
      if (state_out[d] !== expv) begin
         n_bad++; $display("FAIL %s_data d%0d: got %h want %h", nm, d, state_out[d], expv);
      end
      tick();
      n_cmp++;
      if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
         n_bad++; $display("FAIL %s_to_idle d%0d: got ov=%b ir=%b want ov=0 ir=1", nm, d, out_valid[d], in_ready[d]);
      end
   endtask

   task automatic test_reset();
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || state_out[d] !== 128'h0) begin
            n_bad++; $display("FAIL reset_state d%0d: got ir=%b ov=%b so=%h want ir=1 ov=0 so=0",
                              d, in_ready[d], out_valid[d], state_out[d]);
         end
      end
   endtask

   task automatic test_values();
      logic [127:0] mix_in, mix_out;
      mix_in  = '0;
      mix_out = FILL52;
      mix_in[7:0]     = 8'h7c;  mix_out[7:0]     = 8'h01;
      mix_in[47:40]   = 8'hed;  mix_out[47:40]   = 8'h53;
      mix_in[127:120] = 8'h16;  mix_out[127:120] = 8'hff;
      for (int d = 0; d < 3; d++) begin
         send(d, FILL63, 128'h0, "fill63");
         send(d, 128'h0, FILL52, "zero");
         send(d, mix_in, mix_out, "mixed");
         send(d, RT_SUB, RT_ORIG, "roundtrip");
      end
   endtask

   task automatic test_backpressure();
      int n;
      state_in[0]  = RT_SUB;
      in_valid[0]  = 1'b1;
      out_ready[0] = 1'b0;
      tick();
      in_valid[0] = 1'b0;
      n = 0;
      while (out_valid[0] !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      n_cmp++;
      if (out_valid[0] !== 1'b1) begin
         n_bad++; $display("FAIL bp_reach_done: got ov=%b want 1", out_valid[0]);
      end
      for (int c = 0; c < 10; c++) begin
         in_valid[0] = c[0];
         state_in[0] = FILL63;
         tick();
         n_cmp++;
         if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || state_out[0] !== RT_ORIG) begin
            n_bad++; $display("FAIL bp_hold c%0d: got ov=%b ir=%b so=%h want ov=1 ir=0 so=%h",
                              c, out_valid[0], in_ready[0], state_out[0], RT_ORIG);
         end
      end
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      tick();
      n_cmp++;
      if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
         n_bad++; $display("FAIL bp_release: got ir=%b ov=%b want ir=1 ov=0", in_ready[0], out_valid[0]);
      end
      tick();
      n_cmp++;
      if (in_ready[0] !== 1'b1) begin
         n_bad++; $display("FAIL bp_no_capture: got ir=%b want 1", in_ready[0]);
      end
   endtask

   task automatic test_reset_mid();
      state_in[0]  = RT_SUB;
      in_valid[0]  = 1'b1;
      out_ready[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      n_cmp++;
      if (out_valid[0] !== 1'b0 || state_out[0] !== 128'h0 || in_ready[0] !== 1'b1) begin
         n_bad++; $display("FAIL reset_mid: got ov=%b ir=%b so=%h want ov=0 ir=1 so=0",
                           out_valid[0], in_ready[0], state_out[0]);
      end
      tick();
      rst = 1'b0;
      tick();
      send(0, FILL63, 128'h0, "after_reset");
   endtask

   task automatic test_back_to_back();
      logic [127:0] vin  [3];
      logic [127:0] vout [3];
      int acc_cyc [3];
      int acc, m, cyc;
      vin[0] = FILL63; vout[0] = 128'h0;
      vin[1] = 128'h0; vout[1] = FILL52;
      vin[2] = RT_SUB; vout[2] = RT_ORIG;
      for (int d = 0; d < 3; d++) begin
         acc = 0; m = 0; cyc = 0;
         out_ready[d] = 1'b1;
         while (m < 3 && cyc < 80) begin
            if (out_valid[d] === 1'b1) begin
               n_cmp++;
               if (state_out[d] !== vout[m]) begin
                  n_bad++; $display("FAIL b2b_data d%0d blk%0d: got %h want %h", d, m, state_out[d], vout[m]);
               end
               m++;
            end
            in_valid[d] = (acc < 3);
            state_in[d] = vin[(acc < 3) ? acc : 2];
            if (in_valid[d] && in_ready[d] === 1'b1) begin
               acc_cyc[acc] = cyc;
               acc++;
            end
            tick();
            cyc++;
         end
         in_valid[d] = 1'b0;
         n_cmp++;
         if (m != 3 || acc != 3) begin
            n_bad++; $display("FAIL b2b_count d%0d: got out=%0d acc=%0d want 3/3", d, m, acc);
         end else begin
            for (int i = 1; i < 3; i++) begin
               n_cmp++;
               if (acc_cyc[i] - acc_cyc[i-1] != lat_of(d) + 2) begin
                  n_bad++; $display("FAIL b2b_period d%0d: got %0d want %0d",
                                    d, acc_cyc[i] - acc_cyc[i-1], lat_of(d) + 2);
               end
            end
         end
         tick();
      end
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         in_valid[d]  = 1'b0;
         out_ready[d] = 1'b0;
         state_in[d]  = '0;
      end
      #2;
      test_reset();
      tick();
      rst = 1'b0;
      tick();
      test_reset();
      test_values();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
- Sequential inverse SubBytes for the AES decrypt datapath. It is the counterpart of the forward SubBytes stage.
- Accepts a 128-bit state through a valid/ready handshake. It substitutes every byte through a shared bank of LANES inverse S-boxes over 16/LANES cycles, then presents the result through a valid/ready handshake.
- Sits between inverse ShiftRows and AddRoundKey in the decryption round loop. It trades throughput for S-box area.

Parameters:
- LANES, 4, number of inverse S-box instances (bytes substituted per cycle). Legal values: 1, 2, 4, 8, 16. Any other value is a elaboration error.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  state_in is valid
- in_ready  output  1  block can accept a new state
- state_in  input  128  ciphertext-side state; byte i = state_in[8*i +: 8], i = 0..15
- out_valid  output  1  state_out holds a complete result
- out_ready  input  1  downstream accepts the result
- state_out  output  128  inverse-substituted state; byte i = InvSbox(state_in byte i)

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset state:
  - FSM = IDLE; work register = 0; group counter = 0.
  - out_valid = 0; state_out = 0; in_ready = 1 (decoded from IDLE, so it also reads 1 while rst is held).
- FSM states are IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge where in_valid && in_ready: capture state_in into the work register, set cnt = 0, go to BUSY.
- BUSY:
  - in_ready = 0; out_valid = 0.
  - Each cycle replaces bytes cnt*LANES .. cnt*LANES+LANES-1 in place with InvSbox(byte), then increments cnt.
  - Other bytes are untouched.
  - When cnt = 16/LANES-1, the write completes the last group and the FSM goes to DONE.
- DONE:
  - out_valid = 1; in_ready = 0.
  - state_out is stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE at that edge. out_valid drops after the edge.
- Latency: out_valid rises 16/LANES edges after the accept edge (4 for the default). Edges are counted from the accept edge exclusive.
- Throughput: one block per 16/LANES + 2 cycles when out_ready is held at 1.
- state_out is driven from the work register. Its value is defined only while out_valid = 1. During BUSY it shows partially substituted data, and the bench must not check it then.
- Counter width is clog2(16/LANES), minimum 1 bit. With LANES = 16, BUSY lasts exactly one cycle.
- in_valid while not IDLE is ignored; no capture occurs and the source must hold its data.
- in_valid may deassert at any time before acceptance without effect.
- out_ready while not DONE is ignored.
- Reset asserted mid-BUSY or in DONE aborts the operation immediately. All outputs take their reset values and the partial result is discarded.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- The inverse S-box is the FIPS-197 InvSbox, implemented as pure combinational logic.

Decomposition:
- Shared AES package holds:
  - STATE_W = 128, BYTE_W = 8, NUM_BYTES = 16.
  - The InvSbox 256-entry constant table, alongside the forward Sbox table.
- One sub-module, inv_sbox: combinational 8-bit in / 8-bit out lookup of the package table, instantiated LANES times via generate.
- The group byte select and write-back mux stays in the parent.

Test Plan:
- All bytes 0x63 in, out_ready=1, LANES=4 → out_valid rises exactly 4 edges after accept; state_out = all 0x00.
- state_in = 128'h0 → state_out = all 0x52. Mixed bytes 0x7c, 0xed, 0x16 → 0x01, 0x53, 0xff respectively, each in its original byte position.
- Round trip: apply forward SubBytes to FIPS-197 Appendix B round-1 start_of_round state 19a09ae93df4c6f8e3e28d48be2b2a08, feed the result → output equals 19a09ae93df4c6f8e3e28d48be2b2a08.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, state_out unchanged, in_ready=0, and in_valid pulses are ignored. Raise out_ready → IDLE next edge, in_ready=1.
- Reset mid-operation: assert rst 2 cycles after accept → out_valid=0, state_out=0, in_ready=1 asynchronously. After release, a new state 0x63-filled completes normally with full latency.
- Back-to-back with in_valid and out_ready tied high → accepts every 6 cycles (LANES=4). Repeat with LANES=1 (latency 16) and LANES=16 (latency 1) and check the same values.
